// File: rtl/fifo_read_streamer.sv
// Read-side consumer of the async FIFO: pops words into a 2-entry buffer and
// presents them on a valid/ready stream, with flush and debug counters.
module fifo_read_streamer #(
  parameter int DATA  = 8,
  parameter int CNT_W = 16
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic             rempty,
  input  logic [DATA-1:0]  rdata,
  output logic             rinc,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [DATA-1:0]  m_data,
  input  logic             flush,
  output logic             flush_done,
  output logic [CNT_W-1:0] rd_count,
  output logic [CNT_W-1:0] drop_count
);

  typedef enum logic [0:0] {ST_STREAM = 1'b0, ST_FLUSH = 1'b1} state_t;

  state_t           state_r, state_s;
  logic [1:0]       occ_r, occ_s, occ_mid_s;
  logic [DATA-1:0]  head_r, head_s, tail_r, tail_s;
  logic [CNT_W-1:0] rd_count_r, rd_count_s, drop_count_r, drop_count_s;
  logic             m_valid_r, flush_done_r, flush_done_s, hs_s;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                               input logic [1:0] inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, cnt} + {{(CNT_W-1){1'b0}}, inc};
    if (sum[CNT_W]) sat_add = {CNT_W{1'b1}};
    else            sat_add = sum[CNT_W-1:0];
  endfunction

  // Pop strobe: depends on registered state and rempty only, never on m_ready.
  always_comb begin
    rinc = 1'b0;
    if (rrst || rempty) begin
      rinc = 1'b0;
    end else begin
      case (state_r)
        ST_STREAM: rinc = (occ_r != 2'd2);
        ST_FLUSH:  rinc = 1'b1;
        default:   rinc = 1'b0;
      endcase
    end
  end

  assign hs_s = m_valid_r && m_ready;

  // Next-state, buffer and counter update.
  always_comb begin
    state_s      = state_r;
    occ_s        = occ_r;
    occ_mid_s    = occ_r;
    head_s       = head_r;
    tail_s       = tail_r;
    rd_count_s   = rd_count_r;
    drop_count_s = drop_count_r;
    flush_done_s = 1'b0;
    case (state_r)
      ST_STREAM: begin
        // Retire first so a same-cycle push lands in the freed slot.
        if (hs_s) begin
          head_s     = tail_r;
          occ_mid_s  = occ_r - 2'd1;
          rd_count_s = sat_add(rd_count_r, 2'd1);
        end else begin
          occ_mid_s  = occ_r;
        end
        if (rinc) begin
          if (occ_mid_s == 2'd0) head_s = rdata;
          else                   tail_s = rdata;
          occ_s = occ_mid_s + 2'd1;
        end else begin
          occ_s = occ_mid_s;
        end
        if (flush) begin
          drop_count_s = sat_add(drop_count_r, occ_s);
          occ_s        = 2'd0;
          state_s      = ST_FLUSH;
        end else begin
          state_s      = ST_STREAM;
        end
      end
      ST_FLUSH: begin
        occ_s = 2'd0;
        if (rinc) drop_count_s = sat_add(drop_count_r, 2'd1);
        else      drop_count_s = drop_count_r;
        if (rempty) begin
          state_s      = ST_STREAM;
          flush_done_s = 1'b1;
        end else begin
          state_s      = ST_FLUSH;
        end
      end
      default: begin
        state_s = ST_STREAM;
        occ_s   = 2'd0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      state_r      <= ST_STREAM;
      occ_r        <= 2'd0;
      head_r       <= {DATA{1'b0}};
      tail_r       <= {DATA{1'b0}};
      rd_count_r   <= {CNT_W{1'b0}};
      drop_count_r <= {CNT_W{1'b0}};
      m_valid_r    <= 1'b0;
      flush_done_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      occ_r        <= occ_s;
      head_r       <= head_s;
      tail_r       <= tail_s;
      rd_count_r   <= rd_count_s;
      drop_count_r <= drop_count_s;
      m_valid_r    <= (occ_s != 2'd0);
      flush_done_r <= flush_done_s;
    end
  end

  assign m_valid    = m_valid_r;
  assign m_data     = head_r;
  assign flush_done = flush_done_r;
  assign rd_count   = rd_count_r;
  assign drop_count = drop_count_r;

endmodule

// File: tb/tb_fifo_read_streamer.sv
// Self-checking bench for fifo_read_streamer: directed scenarios plus random
// traffic, compared each cycle against a queue-based reference model.
module tb_fifo_read_streamer;
  localparam int DATA  = 8;
  localparam int CNT_W = 4;
  localparam int SAT   = 15;

  logic             rclk = 1'b0;
  logic             rrst, rempty, rinc, m_valid, m_ready, flush, flush_done;
  logic [DATA-1:0]  rdata, m_data;
  logic [CNT_W-1:0] rd_count, drop_count;

  int tests = 0;
  int fails = 0;

  logic [DATA-1:0] fifo_q[$];
  logic [DATA-1:0] mq[$];
  bit in_flush, fdone;
  int rdc, dpc;

  fifo_read_streamer #(.DATA(DATA), .CNT_W(CNT_W)) dut (
    .rclk(rclk), .rrst(rrst), .rempty(rempty), .rdata(rdata), .rinc(rinc),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .flush(flush),
    .flush_done(flush_done), .rd_count(rd_count), .drop_count(drop_count)
  );

  always #5 rclk = ~rclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > SAT) ? SAT : v;
  endfunction

  task automatic drive_fifo();
    rempty = (fifo_q.size() == 0);
    rdata  = rempty ? 8'h00 : fifo_q[0];
  endtask

  task automatic model_reset();
    mq.delete();
    in_flush = 1'b0;
    fdone    = 1'b0;
    rdc      = 0;
    dpc      = 0;
  endtask

  // Called at a falling edge; checks outputs, then advances one rclk.
  task automatic cycle(input logic mr, input logic fl);
    bit exp_rinc;
    logic [DATA-1:0] w;
    m_ready = mr;
    flush   = fl;
    drive_fifo();
    #1;
    exp_rinc = !rempty && (in_flush || mq.size() < 2);
    w = rdata;
    check("rinc", rinc, exp_rinc);
    check("m_valid", m_valid, mq.size() != 0);
    if (mq.size() != 0) check("m_data", m_data, mq[0]);
    check("rd_count", rd_count, rdc);
    check("drop_count", drop_count, dpc);
    check("flush_done", flush_done, fdone);
    @(posedge rclk);
    fdone = 1'b0;
    if (!in_flush) begin
      if (mq.size() != 0 && mr) begin
        void'(mq.pop_front());
        rdc = sat(rdc + 1);
      end
      if (exp_rinc) mq.push_back(w);
      if (fl) begin
        dpc = sat(dpc + mq.size());
        mq.delete();
        in_flush = 1'b1;
      end
    end else begin
      if (exp_rinc) dpc = sat(dpc + 1);
      if (rempty) begin
        in_flush = 1'b0;
        fdone    = 1'b1;
      end
    end
    if (exp_rinc) void'(fifo_q.pop_front());
    @(negedge rclk);
  endtask

  task automatic do_reset(input int n);
    rrst = 1'b1;
    model_reset();
    for (int i = 0; i < n; i++) begin
      drive_fifo();
      #1;
      check("rst_rinc", rinc, 1'b0);
      check("rst_m_valid", m_valid, 1'b0);
      check("rst_rd_count", rd_count, 0);
      check("rst_drop_count", drop_count, 0);
      check("rst_flush_done", flush_done, 1'b0);
      @(negedge rclk);
    end
    rrst = 1'b0;
  endtask

  initial begin
    rrst    = 1'b1;
    m_ready = 1'b0;
    flush   = 1'b0;
    fifo_q  = '{8'hA5, 8'h5A};
    drive_fifo();
    #2;
    do_reset(3);

    // Plain streaming with a ready sink.
    fifo_q.delete();
    fifo_q = '{8'h11, 8'h22, 8'h33};
    repeat (6) cycle(1'b1, 1'b0);
    check("t2_rd_count", rd_count, 3);

    // Backpressure: buffer fills to two, head held.
    do_reset(1);
    fifo_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    repeat (5) cycle(1'b0, 1'b0);
    check("t3_m_data_held", m_data, 8'h01);
    check("t3_fifo_left", fifo_q.size(), 2);
    repeat (6) cycle(1'b1, 1'b0);
    check("t3_rd_count", rd_count, 4);

    // Flush with full buffer and five words left in the FIFO.
    do_reset(1);
    for (int i = 0; i < 7; i++) fifo_q.push_back(8'h40 + i[7:0]);
    repeat (3) cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);
    check("t4_m_valid_off", m_valid, 1'b0);
    repeat (3) cycle(1'b0, 1'b1);
    repeat (5) cycle(1'b0, 1'b0);
    check("t4_drop_count", drop_count, 7);
    check("t4_rd_count", rd_count, 0);

    // Flush coinciding with a handshake.
    do_reset(1);
    fifo_q = '{8'h61, 8'h62};
    repeat (3) cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b1);
    repeat (3) cycle(1'b0, 1'b0);
    check("t5_rd_count", rd_count, 1);
    check("t5_drop_count", drop_count, 1);

    // Counter saturation.
    do_reset(1);
    for (int i = 0; i < 20; i++) fifo_q.push_back(i[7:0]);
    repeat (24) cycle(1'b1, 1'b0);
    check("t6_rd_sat", rd_count, 15);

    // Reset in the middle of a flush: no flush_done afterwards.
    do_reset(1);
    for (int i = 0; i < 8; i++) fifo_q.push_back(8'h80 + i[7:0]);
    repeat (2) cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);
    do_reset(1);
    fifo_q.delete();
    repeat (4) cycle(1'b0, 1'b0);

    // Random traffic against the model.
    do_reset(1);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(2, 0) == 0) fifo_q.push_back(8'($urandom));
      cycle(1'($urandom_range(1, 0)), ($urandom_range(29, 0) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
